// File: rtl/lif_sched_pkg.sv
// Shared definitions for the LIF neuron scheduler: FSM encoding and the
// default firing threshold / leak shift.
package lif_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    localparam logic [7:0] DEF_THRESHOLD   = 8'd200;
    localparam int         DEF_DECAY_SHIFT = 1;

endpackage

// File: rtl/lif_scheduler_update.sv
// Combinational leaky-integrate-and-fire update for one neuron:
// leak by right shift, add input current with saturation at 255,
// fire and reset the membrane to 0 when the threshold is reached.
module lif_update #(
    parameter logic [7:0] THRESHOLD   = 8'd200,
    parameter int         DECAY_SHIFT = 1
) (
    input  logic [7:0] state_in,
    input  logic [7:0] current,
    output logic [7:0] state_next,
    output logic       spike
);

    logic [8:0] sum9;
    logic [7:0] sum_sat;

    // Leak, integrate, saturate, then compare against the threshold.
    always_comb begin
        sum9       = {1'b0, (state_in >> DECAY_SHIFT)} + {1'b0, current};
        sum_sat    = sum9[8] ? 8'hFF : sum9[7:0];
        spike      = (sum_sat >= THRESHOLD);
        state_next = spike ? 8'd0 : sum_sat;
    end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF scheduler: one update datapath sweeps N_NEURONS
// virtual neurons per timestep (tick). Spikes of a sweep are published on
// spike_vec with a one-cycle spike_valid pulse. Ticks arriving while busy
// are dropped and recorded in the sticky overrun flag.
// Optional build macro: LIF_SCHED_REFRACTORY_EN adds a per-neuron
// refractory bit that suppresses the update following a spike.
// fsm_state exposes the FSM encoding for debug and checker binding.
module lif_scheduler
    import lif_sched_pkg::*;
#(
    parameter int         N_NEURONS   = 4,
    parameter logic [7:0] THRESHOLD   = DEF_THRESHOLD,
    parameter int         DECAY_SHIFT = DEF_DECAY_SHIFT,
    localparam int        AW          = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [7:0]           wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [7:0]           state_out,
    output logic [N_NEURONS-1:0] spike_vec,
    output logic                 spike_valid,
    output logic                 busy,
    output logic                 overrun,
    output sched_state_t         fsm_state
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

    sched_state_t         state_q, state_d;
    logic [AW-1:0]        idx_q;
    logic [7:0]           mem_q [N_NEURONS];
    logic [7:0]           cur_q [N_NEURONS];
    logic [N_NEURONS-1:0] acc_q;
`ifdef LIF_SCHED_REFRACTORY_EN
    logic [N_NEURONS-1:0] refr_q;
`endif

    logic [7:0] upd_state;
    logic       upd_spike;

    lif_update #(
        .THRESHOLD   (THRESHOLD),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_update (
        .state_in   (mem_q[idx_q]),
        .current    (cur_q[idx_q]),
        .state_next (upd_state),
        .spike      (upd_spike)
    );

    assign busy      = (state_q != ST_IDLE);
    assign state_out = mem_q[rd_addr];
    assign fsm_state = state_q;

    // Next-state logic: start on tick, sweep every index once, publish, return.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (tick) state_d = ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, sweep datapath, register files and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            spike_vec   <= '0;
            spike_valid <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= 8'd0;
                cur_q[i] <= 8'd0;
            end
`ifdef LIF_SCHED_REFRACTORY_EN
            refr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            spike_valid <= (state_q == ST_DONE);
            if (tick && busy) overrun <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        idx_q <= '0;
                        acc_q <= '0;
                    end
                end
                ST_RUN: begin
`ifdef LIF_SCHED_REFRACTORY_EN
                    if (refr_q[idx_q]) begin
                        mem_q[idx_q]  <= 8'd0;
                        acc_q[idx_q]  <= 1'b0;
                        refr_q[idx_q] <= 1'b0;
                    end else begin
                        mem_q[idx_q]  <= upd_state;
                        acc_q[idx_q]  <= upd_spike;
                        refr_q[idx_q] <= upd_spike;
                    end
`else
                    mem_q[idx_q] <= upd_state;
                    acc_q[idx_q] <= upd_spike;
`endif
                    idx_q <= idx_q + 1'b1;
                end
                ST_DONE: spike_vec <= acc_q;
                default: ;
            endcase

            // The update above reads the pre-edge current, so a same-cycle
            // write to the active neuron only affects the next timestep.
            if (wr_en) cur_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: number of virtual neurons time-multiplexed onto one update datapath (power of two, 2..8).
REQ-002 SHALL have parameter THRESHOLD, default 8'd200: firing threshold.
REQ-003 SHALL have parameter DECAY_SHIFT, default 1: leak is applied as a right shift of the membrane state.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  timestep request; sampled every cycle.
REQ-007 wr_en  input  1  write enable for the input-current register file.
REQ-008 wr_addr  input  log2(N_NEURONS)  neuron index for the write.
REQ-009 wr_data  input  8  unsigned input current.
REQ-010 rd_addr  input  log2(N_NEURONS)  neuron index for state readback.
REQ-011 state_out  output  8  membrane state of neuron rd_addr, combinational read of the state register.
REQ-012 spike_vec  output  N_NEURONS  spikes of the last completed timestep, bit i = neuron i.
REQ-013 spike_valid  output  1  one-cycle pulse when spike_vec updates.
REQ-014 busy  output  1  high while a sweep is in progress.
REQ-015 overrun  output  1  sticky flag: a tick was dropped.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; IDLE->RUN on tick=1; RUN lasts exactly N_NEURONS cycles with index 0..N_NEURONS-1; RUN->DONE after the last index; DONE->IDLE unconditionally.
REQ-017 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-018 Each RUN cycle SHALL update neuron idx: sum = (state >> DECAY_SHIFT) + current, 9-bit, saturated to 8'd255.
REQ-019 If sum >= THRESHOLD, the neuron SHALL spike: the state is written to 0 and its bit is set in an internal spike accumulator; otherwise the state is written to sum.
REQ-020 In DONE, spike_vec SHALL load the accumulator and spike_valid SHALL pulse for that one cycle; the accumulator clears on entry to RUN.
REQ-021 Latency: with tick sampled high at edge k, spike_valid SHALL be high during the cycle following edge k+N_NEURONS+1.
REQ-022 Writes SHALL be accepted in any state; a write to the neuron being updated in the same cycle SHALL take effect only from the next timestep (the update uses the old current).
REQ-023 tick=1 while busy=1 SHALL be ignored and SHALL set overrun, which clears only on rst.
REQ-024 spike_vec SHALL hold its value between DONE cycles.

Reset
REQ-025 On rst=1, the FSM SHALL go to IDLE, all membrane states, currents and spike_vec to 0, and spike_valid, busy and overrun to 0.
REQ-026 rst SHALL abort an in-progress sweep with no spike_valid pulse; rst has priority over tick and wr_en.

Configuration
REQ-027 Macro LIF_SCHED_REFRACTORY_EN: when defined, each neuron SHALL keep a refractory bit that is set on a spike; in the neuron's next RUN update it SHALL skip integration, keep state 0, not spike, and clear the bit.
REQ-028 Without LIF_SCHED_REFRACTORY_EN, no refractory storage SHALL exist and every update SHALL follow REQ-018/REQ-019.

Structure
REQ-029 Package lif_sched_pkg SHALL hold the FSM state encoding (IDLE, RUN, DONE) and the default THRESHOLD and DECAY_SHIFT constants.
REQ-030 The update arithmetic (REQ-018/REQ-019) SHALL sit in a combinational sub-module lif_update; lif_scheduler holds the FSM, the register files and the output registers.

Verification
REQ-031 Reset: assert rst for 2 cycles -> spike_vec=0, spike_valid=0, busy=0, overrun=0, state_out=0 for every rd_addr.
REQ-032 Integration: neuron0 current=120, ticks spaced 10 cycles -> state 120, then 180, then spike (spike_vec[0]=1, state 0) on the third tick.
REQ-033 Timing: tick at edge k with N=4 -> busy high cycles k+1..k+5; spike_valid pulse exactly after edge k+5; one pulse per tick.
REQ-034 Saturation: current=255, threshold overridden to 255 -> sum clipped to 255, spike, state 0; no wrap to small values.
REQ-035 Overrun and mid-sweep reset: tick again 2 cycles after a tick -> ignored and overrun=1; then rst during RUN -> no spike_valid, all state 0, overrun=0.
REQ-036 Refractory (macro defined): current=250 -> spike at t1, state 0 with no spike at t2, spike at t3; with the macro undefined -> spike at t1, t2 and t3.
